// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, a constant clog2 helper and the read-master FSM states.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_4K_BYTES = 4096;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/axi_burst_len_fifo.sv
// Small synchronous FIFO holding the ARLEN of every burst still in flight.
module axi_burst_len_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4 read burst master: splits a beat-count command into 4 KB-safe INCR bursts,
// keeps several in flight and streams the returned data to a local consumer.
//
//   state   | meaning
//   IDLE    | waiting for INIT_AXI_TXN; command latched on start
//   RUN     | issuing ARs and forwarding R beats until the final burst's RLAST
//   DONE    | one-cycle TXN_DONE pulse, then back to IDLE
module axi_burst_read_master
  import axi_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_OUTSTANDING  = 4,
  parameter int C_LEN_WIDTH        = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          INIT_AXI_TXN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [C_LEN_WIDTH-1:0]        CMD_BEATS,
  output logic                          BUSY,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] DOUT_DATA,
  output logic                          DOUT_VALID,
  input  logic                          DOUT_READY,
  output logic                          DOUT_LAST
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SIZE  = clog2(BYTES);
  localparam int LW    = C_LEN_WIDTH + 1;
  localparam int CW    = (LW > 14) ? LW : 14;
  localparam int CNT_W = clog2(C_MAX_OUTSTANDING + 1);

  state_e                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]                 rem_q, rem_d;
  logic [C_LEN_WIDTH-1:0]        total_q, total_d;
  logic [LW-1:0]                 rx_cnt_q, rx_cnt_d;
  logic [7:0]                    beat_cnt_q, beat_cnt_d;
  logic                          err_q, err_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] last_araddr_q, last_araddr_d;
  logic [7:0]                    last_arlen_q, last_arlen_d;

  logic [CW-1:0]    cur_len;
  logic [7:0]       cur_arlen;
  logic             run, ar_valid, ar_hs, r_hs, beat_bad;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Beats allowed in the next burst: remaining, max burst, and room left in the 4 KB page.
  function automatic logic [CW-1:0] burst_len(input logic [11:0] page_off,
                                              input logic [LW-1:0] remaining);
    logic [CW-1:0] room;
    logic [CW-1:0] len;
    room = (CW'(AXI_4K_BYTES) - CW'(page_off)) >> SIZE;
    len  = CW'(remaining);
    if (len > CW'(C_M_AXI_BURST_LEN)) len = CW'(C_M_AXI_BURST_LEN);
    if (len > room) len = room;
    return len;
  endfunction

  assign cur_len   = burst_len(addr_q[11:0], rem_q);
  assign cur_arlen = 8'(cur_len - CW'(1));
  assign run       = (state_q == ST_RUN);
  assign ar_valid  = run && (rem_q != '0) && !fifo_full;
  assign ar_hs     = ar_valid && M_AXI_ARREADY;
  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = ar_valid ? addr_q : last_araddr_q;
  assign M_AXI_ARLEN   = ar_valid ? cur_arlen : last_arlen_q;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARVALID = ar_valid;

  assign M_AXI_RREADY = run && DOUT_READY;
  assign DOUT_DATA    = M_AXI_RDATA;
  assign DOUT_VALID   = run && M_AXI_RVALID;
  assign DOUT_LAST    = DOUT_VALID && ((rx_cnt_q + LW'(1)) == LW'(total_q));

  assign BUSY     = (state_q != ST_IDLE);
  assign TXN_DONE = (state_q == ST_DONE);
  assign ERROR    = err_q;

  // Only ID 0 is ever issued, so any other RID is treated like a bad response.
  assign beat_bad = (M_AXI_RRESP == RESP_SLVERR) || (M_AXI_RRESP == RESP_DECERR) ||
                    (M_AXI_RID != '0) || fifo_empty ||
                    (M_AXI_RLAST != (beat_cnt_q == fifo_head));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    total_d       = total_q;
    rx_cnt_d      = rx_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    last_araddr_d = last_araddr_q;
    last_arlen_d  = last_arlen_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INIT_AXI_TXN) begin
          err_d      = 1'b0;
          addr_d     = CMD_ADDR;
          rem_d      = LW'(CMD_BEATS);
          total_d    = CMD_BEATS;
          rx_cnt_d   = '0;
          beat_cnt_d = '0;
          state_d    = (CMD_BEATS == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ar_hs) begin
          fifo_push     = 1'b1;
          addr_d        = addr_q + (C_M_AXI_ADDR_WIDTH'(cur_len) << SIZE);
          rem_d         = rem_q - LW'(cur_len);
          last_araddr_d = addr_q;
          last_arlen_d  = cur_arlen;
        end
        if (r_hs) begin
          rx_cnt_d = rx_cnt_q + LW'(1);
          if (beat_bad) err_d = 1'b1;
          if (M_AXI_RLAST) begin
            fifo_pop   = !fifo_empty;
            beat_cnt_d = '0;
            // No push can coincide here because nothing remains to issue.
            if ((rem_q == '0) && (fifo_count == CNT_W'(1))) state_d = ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      total_q       <= '0;
      rx_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      last_araddr_q <= '0;
      last_arlen_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      total_q       <= total_d;
      rx_cnt_q      <= rx_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      last_araddr_q <= last_araddr_d;
      last_arlen_q  <= last_arlen_d;
    end
  end

  axi_burst_len_fifo #(
    .DEPTH (C_MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_len_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .push  (fifo_push),
    .wdata (cur_arlen),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench for axi_burst_read_master with a behavioural AXI read slave.
module tb_axi_burst_read_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        M_AXI_ARESET, INIT_AXI_TXN;
  logic [31:0] CMD_ADDR;
  logic [15:0] CMD_BEATS;
  logic        BUSY, TXN_DONE, ERROR;
  logic [0:0]  M_AXI_ARID, M_AXI_RID;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, DOUT_DATA;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP;
  logic        M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [3:0]  M_AXI_ARCACHE, M_AXI_ARQOS;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic        DOUT_VALID, DOUT_READY, DOUT_LAST;

  always #5 clk = ~clk;

  axi_burst_read_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET), .INIT_AXI_TXN(INIT_AXI_TXN),
    .CMD_ADDR(CMD_ADDR), .CMD_BEATS(CMD_BEATS), .BUSY(BUSY), .TXN_DONE(TXN_DONE),
    .ERROR(ERROR), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .DOUT_DATA(DOUT_DATA), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_LAST(DOUT_LAST)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit ar_rand = 0, dr_rand = 0, r_en = 1, skip_data = 0;
  int err_at = -1, prem_at = -1;

  logic [31:0] q_addr[$];
  int          q_len[$];
  int          sb = 0, sg = 0;

  logic [31:0] ar_addr_log[$];
  int          ar_len_log[$];
  int          ar_cyc_log[$];
  int rx_n, data_bad, last_bad, last_seen, rready_bad, stab_bad;
  int first_rlast_cyc, last_rlast_cyc, err_beat_cyc, err_rise_cyc;
  logic [31:0] exp_base;
  int          exp_total;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: drive at posedge+1, observe handshakes at negedge.
  initial begin
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
    M_AXI_RDATA = 0; M_AXI_RID = 0; DOUT_READY = 0;
    forever begin
      @(posedge clk); #1;
      M_AXI_ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      DOUT_READY    = dr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_en && q_addr.size() > 0) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = (q_addr[0] >> 2) + 32'(sb);
        M_AXI_RLAST  = (sb == q_len[0]) || (sg == prem_at);
        M_AXI_RRESP  = (sg == err_at) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = RESP_OKAY; M_AXI_RDATA = '0;
      end
      @(negedge clk);
      if (M_AXI_ARESET) begin
        q_addr.delete(); q_len.delete(); sb = 0; sg = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!M_AXI_ARVALID || M_AXI_ARADDR !== prev_addr || M_AXI_ARLEN !== prev_len))
          stab_bad++;
        prev_stall = M_AXI_ARVALID && !M_AXI_ARREADY;
        prev_addr  = M_AXI_ARADDR;
        prev_len   = M_AXI_ARLEN;
        if (M_AXI_RREADY !== (DOUT_READY && BUSY && !TXN_DONE)) rready_bad++;
        if (ERROR && err_rise_cyc < 0) err_rise_cyc = cyc;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          q_addr.push_back(M_AXI_ARADDR);
          q_len.push_back(int'(M_AXI_ARLEN));
          ar_addr_log.push_back(M_AXI_ARADDR);
          ar_len_log.push_back(int'(M_AXI_ARLEN));
          ar_cyc_log.push_back(cyc);
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          if (!skip_data) begin
            if (DOUT_DATA !== exp_base + 32'(rx_n) || DOUT_VALID !== 1'b1) data_bad++;
            if (DOUT_LAST !== (rx_n == exp_total - 1)) last_bad++;
          end
          if (DOUT_LAST) last_seen++;
          if (M_AXI_RRESP == RESP_SLVERR) err_beat_cyc = cyc;
          if (M_AXI_RLAST) begin
            if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
            last_rlast_cyc = cyc;
            void'(q_addr.pop_front());
            void'(q_len.pop_front());
            sb = 0;
          end else begin
            sb++;
          end
          sg++;
          rx_n++;
        end
      end
    end
  end

  task automatic start(input logic [31:0] a, input int n);
    @(negedge clk); #1;
    ar_addr_log.delete(); ar_len_log.delete(); ar_cyc_log.delete();
    rx_n = 0; data_bad = 0; last_bad = 0; last_seen = 0; rready_bad = 0; stab_bad = 0;
    first_rlast_cyc = -1; last_rlast_cyc = -1; err_beat_cyc = -1; err_rise_cyc = -1; sg = 0;
    exp_base = a >> 2; exp_total = n;
    @(posedge clk); #1;
    CMD_ADDR = a; CMD_BEATS = 16'(n); INIT_AXI_TXN = 1'b1;
    @(posedge clk); #1;
    INIT_AXI_TXN = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (TXN_DONE !== 1'b1 && n < limit);
    if (TXN_DONE !== 1'b1) begin
      check({tag, " timeout"}, 64'd0, 64'd1);
      return;
    end
    #1;
    check({tag, " done_latency"}, 64'(cyc), 64'(last_rlast_cyc + 1));
    @(negedge clk);
    check({tag, " busy_done_fall"}, {62'd0, BUSY, TXN_DONE}, 64'd0);
  endtask

  initial begin
    M_AXI_ARESET = 1'b1; INIT_AXI_TXN = 1'b0; CMD_ADDR = '0; CMD_BEATS = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", {M_AXI_ARVALID, M_AXI_RREADY, BUSY, TXN_DONE, ERROR, DOUT_LAST}, 64'd0);
    check("reset araddr", M_AXI_ARADDR, 64'd0);
    check("reset arlen", M_AXI_ARLEN, 64'd0);
    check("const ar fields", {M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
                              M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS},
          {1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    @(posedge clk); #1;
    M_AXI_ARESET = 1'b0;

    // aligned 64 beats
    start(32'h4000_0000, 64);
    @(negedge clk);
    check("t1 arvalid cycle1", M_AXI_ARVALID, 64'd1);
    check("t1 first araddr", M_AXI_ARADDR, 64'h4000_0000);
    wait_done(500, "t1");
    check("t1 ar count", ar_addr_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < ar_addr_log.size(); i++) begin
      check($sformatf("t1 araddr%0d", i), ar_addr_log[i], 64'h4000_0000 + 64'(i * 64));
      check($sformatf("t1 arlen%0d", i), ar_len_log[i], 64'd15);
    end
    check("t1 beats", rx_n, 64'd64);
    check("t1 data", data_bad, 64'd0);
    check("t1 last", {last_bad, last_seen}, {32'd0, 32'd1});
    check("t1 error", ERROR, 64'd0);

    // 4 KB crossing
    start(32'h4000_0FF0, 20);
    wait_done(500, "t2");
    check("t2 ar count", ar_addr_log.size(), 64'd2);
    if (ar_addr_log.size() >= 2) begin
      check("t2 ar0", {ar_addr_log[0], ar_len_log[0]}, {32'h4000_0FF0, 32'd3});
      check("t2 ar1", {ar_addr_log[1], ar_len_log[1]}, {32'h4000_1000, 32'd15});
    end
    check("t2 data", {data_bad, last_bad}, 64'd0);

    // outstanding limit
    r_en = 0;
    start(32'h0000_0000, 128);
    repeat (50) @(negedge clk);
    #1;
    check("t3 ar count stalled", ar_addr_log.size(), 64'd4);
    check("t3 arvalid stalled", M_AXI_ARVALID, 64'd0);
    r_en = 1;
    wait_done(1000, "t3");
    check("t3 ar count", ar_addr_log.size(), 64'd8);
    if (ar_cyc_log.size() >= 5)
      check("t3 fifth ar timing", 64'(ar_cyc_log[4]), 64'(first_rlast_cyc + 1));
    check("t3 beats", rx_n, 64'd128);
    check("t3 data", {data_bad, last_bad}, 64'd0);

    // random backpressure on ARREADY and DOUT_READY
    ar_rand = 1; dr_rand = 1;
    start(32'h0000_0000, 256);
    wait_done(6000, "t4");
    check("t4 beats", rx_n, 64'd256);
    check("t4 data", {data_bad, last_bad}, 64'd0);
    check("t4 ar stable", stab_bad, 64'd0);
    check("t4 rready mirror", rready_bad, 64'd0);
    check("t4 ar count", ar_addr_log.size(), 64'd16);
    ar_rand = 0; dr_rand = 0;

    // SLVERR on beat 5 of burst 2
    err_at = 20;
    start(32'h0000_1000, 64);
    wait_done(1000, "t5");
    check("t5 error rise", 64'(err_rise_cyc), 64'(err_beat_cyc + 1));
    check("t5 data", {data_bad, last_bad}, 64'd0);
    repeat (3) @(negedge clk);
    check("t5 error sticky", ERROR, 64'd1);
    err_at = -1;
    start(32'h0000_1000, 16);
    @(negedge clk);
    check("t5 error cleared", ERROR, 64'd0);
    wait_done(500, "t5b");
    check("t5b error", ERROR, 64'd0);

    // premature RLAST on beat 6 of burst 1
    prem_at = 5; skip_data = 1;
    start(32'h0000_0000, 32);
    wait_done(1000, "t6");
    check("t6 error", ERROR, 64'd1);
    check("t6 ar count", ar_addr_log.size(), 64'd2);
    prem_at = -1; skip_data = 0;

    // zero beats
    start(32'h0000_5000, 0);
    @(negedge clk);
    check("t7 cycle1", {M_AXI_ARVALID, TXN_DONE, BUSY}, {1'b0, 1'b1, 1'b1});
    @(negedge clk);
    check("t7 cycle2", {TXN_DONE, BUSY}, 64'd0);
    #1;
    check("t7 no ar", ar_addr_log.size(), 64'd0);

    // reset in the middle of RUN, then a clean transfer
    r_en = 0;
    start(32'h0000_0000, 64);
    repeat (5) @(posedge clk);
    #1;
    M_AXI_ARESET = 1'b1;
    @(posedge clk); #1;
    M_AXI_ARESET = 1'b0;
    @(negedge clk);
    check("t8 reset ctrl", {M_AXI_ARVALID, M_AXI_RREADY, BUSY, TXN_DONE, ERROR, DOUT_LAST}, 64'd0);
    check("t8 reset ar", {M_AXI_ARADDR, M_AXI_ARLEN}, 64'd0);
    r_en = 1;
    start(32'h0000_2000, 16);
    wait_done(500, "t8");
    check("t8 beats", rx_n, 64'd16);
    check("t8 data", {data_bad, last_bad, last_seen}, {21'd0, 21'd0, 22'd1});
    check("t8 ar count", ar_addr_log.size(), 64'd1);
    if (ar_addr_log.size() >= 1)
      check("t8 ar0", {ar_addr_log[0], ar_len_log[0]}, {32'h0000_2000, 32'd15});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/axi_burst_read_master.md
# axi_burst_read_master

Parametrised AXI4 read-only burst master and successor to the single-shot fixed-length test master. It accepts a command with a start address and a total beat count, then splits the transfer into INCR bursts of up to C_M_AXI_BURST_LEN beats that never cross a 4 KB boundary. It keeps up to C_MAX_OUTSTANDING bursts in flight and forwards read data on a valid/ready stream with an end-of-transfer marker. It sits between a local consumer (DMA/rectify datapath) and the AXI interconnect; the write channel lives in a separate master.

## Interface
- C_M_AXI_BURST_LEN, 16: maximum beats per burst; power of two, 1..256.
- C_M_AXI_ID_WIDTH, 1: ARID/RID width.
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width; 32, 64 or 128.
- C_MAX_OUTSTANDING, 4: maximum bursts in flight; power of two, 1..16.
- C_LEN_WIDTH, 16: width of the total beat count.

Ports:
- M_AXI_ACLK  in  1  sole clock; all logic is on the rising edge.
- M_AXI_ARESET  in  1  synchronous reset, active-high.
- INIT_AXI_TXN  in  1  start strobe; sampled only in IDLE.
- CMD_ADDR  in  ADDR_WIDTH  start byte address; aligned to DATA_WIDTH/8.
- CMD_BEATS  in  C_LEN_WIDTH  total beats; 0 is legal.
- BUSY  out  1  high whenever the state is not IDLE.
- TXN_DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  sticky error flag; cleared when a start is accepted.
- M_AXI_ARID, ARADDR, ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARLOCK, ARCACHE[3:0], ARPROT[2:0], ARQOS[3:0], ARVALID  out: AXI4 read address channel.
- M_AXI_ARREADY  in  1.
- M_AXI_RID, RDATA, RRESP[1:0], RLAST, RVALID  in: AXI4 read data channel.
- M_AXI_RREADY  out  1.
- DOUT_DATA  out  DATA_WIDTH  equals M_AXI_RDATA.
- DOUT_VALID  out  1  equals M_AXI_RVALID while in RUN.
- DOUT_READY  in  1  consumer backpressure.
- DOUT_LAST  out  1  marks the final beat of the whole transfer.

## Operation
- **Reset values:** ARVALID 0, RREADY 0, BUSY 0, TXN_DONE 0, ERROR 0. ARADDR holds the last issued address (0 after reset), ARLEN 0, DOUT_LAST 0.
- **Constant AR fields:** ARID 0, ARSIZE log2(DATA_WIDTH/8), ARBURST 2'b01 (INCR), ARLOCK 0, ARCACHE 4'b0011, ARPROT 0, ARQOS 0.
- **FSM states:**
  - IDLE goes to RUN on INIT_AXI_TXN with CMD_BEATS≠0. At that point it latches CMD_ADDR and CMD_BEATS and clears ERROR.
  - IDLE goes directly to DONE when CMD_BEATS=0. No AR is issued.
  - RUN goes to DONE on the RLAST handshake that completes the final burst.
  - DONE asserts TXN_DONE for one cycle, then returns to IDLE.
  - INIT_AXI_TXN is ignored outside IDLE.
- **Burst sizing:**
  - len = min(remaining_beats, C_M_AXI_BURST_LEN, (4096 − addr[11:0]) / BYTES).
  - ARLEN = len−1.
  - On an AR handshake: addr += len·BYTES and remaining_beats −= len.
  - Arithmetic uses C_LEN_WIDTH+1 bits, with no truncation.
- **Issue rule:** ARVALID is asserted when remaining_beats≠0 and the burst-length FIFO is not full. Once asserted, ARVALID, ARADDR and ARLEN stay stable until ARREADY.
- **Read path:**
  - M_AXI_RREADY = DOUT_READY while in RUN, otherwise 0.
  - A beat is accepted when RVALID && RREADY.
  - On each RLAST handshake the head of the FIFO is popped.
- **Error detection:** ERROR sets on an accepted beat under either condition:
  - RRESP[1]=1 (SLVERR or DECERR);
  - RLAST disagrees with the expected last beat, i.e. the per-burst beat counter compared with the FIFO head.
  
  On an error the transfer continues to completion. ERROR holds until the next accepted start or reset.
- **End marker:** DOUT_LAST is high on the accepted beat whose total received count equals CMD_BEATS.
- **Simultaneous events:** an AR handshake (FIFO push) and an RLAST handshake (FIFO pop) in the same cycle leave the occupancy unchanged. A push into a full FIFO cannot occur.
- **Reset mid-transfer:** all state returns to reset values and in-flight bursts are discarded. The interconnect/slave must be reset in the same cycle.

## Timing
- The start is sampled at cycle 0. The first ARVALID is high in cycle 1.
- A new AR may issue every cycle while the FIFO has space.
- RDATA→DOUT_DATA and DOUT_READY→RREADY are combinational, with zero latency.
- TXN_DONE is high in the cycle after the final RLAST handshake. BUSY falls in the same cycle TXN_DONE falls.
- For CMD_BEATS=0: TXN_DONE is high in cycle 1.
- ERROR registers in the cycle after the offending beat.

## Structure
- **Shared package axi_pkg:** AXI_BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_4K_BYTES, a clog2 function, and the FSM state enum.
- **Sub-module axi_burst_len_fifo:** synchronous FIFO with depth C_MAX_OUTSTANDING and width 8, storing ARLEN. It has push/pop/full/empty ports and is reset by M_AXI_ARESET.
- **Top level:** contains the FSM, address/remaining counters, beat counters and the error logic.

## Test plan
- **Aligned transfer:** CMD_ADDR 0x4000_0000, CMD_BEATS 64, 32-bit data, slave always ready.
  - Expect 4 ARs with ARLEN=15 at 0x4000_0000/0040/0080/00C0.
  - 64 beats forwarded in order; DOUT_LAST on beat 64.
  - TXN_DONE pulses 1 cycle after the final RLAST; ERROR 0.
- **4 KB crossing:** CMD_ADDR 0x4000_0FF0, CMD_BEATS 20.
  - Expect AR ARLEN=3 at 0x4000_0FF0, then ARLEN=15 at 0x4000_1000. No burst crosses 0x1000.
- **Outstanding limit:** CMD_BEATS 128, ARREADY=1, RVALID held low for 50 cycles.
  - Exactly 4 ARs issue, then ARVALID stays 0.
  - The 5th AR appears 1 cycle after the first RLAST handshake.
- **Backpressure:** DOUT_READY random at 50%.
  - RREADY mirrors DOUT_READY each cycle.
  - The 256-beat counting pattern is received with no loss or duplication, and ARVALID/ARADDR stay stable under ARREADY stalls.
- **Error response:** SLVERR on beat 5 of burst 2.
  - ERROR rises next cycle; the transfer completes with TXN_DONE.
  - ERROR stays 1 until the next INIT, which clears it.
  - A further test forces a premature RLAST and expects ERROR=1.
- **Boundary cases:**
  - CMD_BEATS 0: TXN_DONE in cycle 1 with no ARVALID.
  - Reset asserted mid-RUN: next cycle all outputs at reset values and BUSY 0; a new 16-beat command then completes correctly.
